// File: rtl/ctrl_fsm.sv
// Multi-cycle sequencer for the 8-bit ALU core: fetch, decode, execute, memory and writeback.
// All outputs are registered; decoded fields are held from DECODE until the next decode.
module ctrl_fsm #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 9,
   parameter int OP_W    = 3,
   parameter int SEL_W   = 3,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   output logic [PC_W-1:0]    pc,
   input  logic [INSTR_W-1:0] instr_in,
   output logic [OP_W-1:0]    alu_op,
   output logic [SEL_W-1:0]   ra_sel,
   output logic [SEL_W-1:0]   rb_sel,
   input  logic               alu_jump,
   output logic               mem_req,
   output logic               mem_we,
   input  logic               mem_ready,
   output logic               reg_we,
   output logic               wb_sel,
   output logic [SEL_W-1:0]   wb_dst,
   output logic               car_we,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   cycles
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'd2;
   localparam logic [2:0] OP_SRL  = 3'd3;
   localparam logic [2:0] OP_SRA  = 3'd4;
   localparam logic [2:0] OP_BEQ  = 3'd5;
   localparam logic [2:0] OP_MEM  = 3'd6;
   localparam logic [2:0] OP_HALT = 3'd7;

   state_t     state;
   logic [2:0] opc;
   logic       is_sw;
   logic [2:0] dec_op;

   assign dec_op = instr_in[INSTR_W-1 -: 3];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         pc      <= '0;
         cycles  <= '0;
         alu_op  <= '0;
         ra_sel  <= '0;
         rb_sel  <= '0;
         wb_dst  <= '0;
         wb_sel  <= 1'b0;
         mem_req <= 1'b0;
         mem_we  <= 1'b0;
         reg_we  <= 1'b0;
         car_we  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         opc     <= '0;
         is_sw   <= 1'b0;
      end else begin
         reg_we <= 1'b0;
         car_we <= 1'b0;
         if (busy)
            cycles <= sat_inc(cycles);

         case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  pc     <= '0;
                  cycles <= '0;
                  busy   <= 1'b1;
                  done   <= 1'b0;
                  state  <= S_FETCH;
               end
            end
            S_FETCH: state <= S_DECODE;
            S_DECODE: begin
               opc   <= dec_op;
               is_sw <= instr_in[5];
               if (dec_op == OP_HALT) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_HALT;
               end else begin
                  alu_op <= OP_W'(dec_op);
                  state  <= S_EXEC;
                  // Memory ops use a 2-bit address register and write back to the data register.
                  if (dec_op == OP_MEM) begin
                     ra_sel <= SEL_W'({1'b0, instr_in[4:3]});
                     rb_sel <= SEL_W'(instr_in[2:0]);
                     wb_dst <= SEL_W'(instr_in[2:0]);
                     wb_sel <= ~instr_in[5];
                     mem_we <= instr_in[5];
                  end else begin
                     ra_sel <= SEL_W'(instr_in[5:3]);
                     rb_sel <= SEL_W'(instr_in[2:0]);
                     wb_dst <= SEL_W'(instr_in[5:3]);
                     wb_sel <= 1'b0;
                  end
               end
            end
            S_EXEC: begin
               case (opc)
                  OP_BEQ: begin
                     pc    <= alu_jump ? pc + PC_W'(2) : pc + PC_W'(1);
                     state <= S_FETCH;
                  end
                  OP_MEM: begin
                     mem_req <= 1'b1;
                     state   <= S_MEM;
                  end
                  default: begin
                     reg_we <= 1'b1;
                     car_we <= (opc == OP_ADD) || (opc == OP_SRL) || (opc == OP_SRA);
                     state  <= S_WB;
                  end
               endcase
            end
            S_MEM: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  if (is_sw) begin
                     pc    <= pc + PC_W'(1);
                     state <= S_FETCH;
                  end else begin
                     reg_we <= 1'b1;
                     state  <= S_WB;
                  end
               end
            end
            S_WB: begin
               pc    <= pc + PC_W'(1);
               state <= S_FETCH;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
